// File: rtl/rx_pkg.sv
// Shared types and widths for the receiver byte-assembly path.
// Nibbles are paired low-first into bytes of the form {high, low}.
package rx_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW_WAIT  = 2'd1,
    HIGH_WAIT = 2'd2
  } asm_state_t;

  function automatic logic [BYTE_W-1:0] pack_byte(input logic [NIB_W-1:0] hi,
                                                   input logic [NIB_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Small byte FIFO with registered storage; the head is presented combinationally.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module rx_byte_fifo
  import rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [BYTE_W-1:0]          push_data,
  input  logic                       pop,
  output logic [BYTE_W-1:0]          data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push_s;
  logic              do_pop_s;

  assign empty     = (count_q == CW'(0));
  assign full      = (count_q == CW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Forced to zero when empty so a drained FIFO never shows a stale byte.
  assign data  = empty ? {BYTE_W{1'b0}} : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rx_byte_assembler.sv
// Pairs receiver nibbles into bytes (low first), watches the inter-nibble gap,
// and buffers completed bytes for a valid/ready consumer.
module rx_byte_assembler
  import rx_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NIB_W-1:0]        nib_data,
  input  logic                    nib_valid,
  output logic [BYTE_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overrun,
  output logic                    timeout_err,
  input  logic                    clr_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  asm_state_t       state_q, state_d;
  logic [NIB_W-1:0] low_q, low_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             overrun_q, overrun_d;
  logic             timeout_err_q, timeout_err_d;

  logic             push_req_s;
  logic             timeout_evt_s;
  logic             overrun_evt_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [BYTE_W-1:0] push_byte_s;

  assign pop_s       = out_valid && out_ready;
  assign push_byte_s = pack_byte(nib_data, low_q);

  always_comb begin
    state_d       = state_q;
    low_d         = low_q;
    timer_d       = timer_q;
    push_req_s    = 1'b0;
    timeout_evt_s = 1'b0;
    // Disabling abandons any partial byte quietly; it is not a fault.
    if (!enable) begin
      state_d = IDLE;
      low_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = LOW_WAIT;
        end
        LOW_WAIT: begin
          if (nib_valid) begin
            low_d   = nib_data;
            timer_d = '0;
            state_d = HIGH_WAIT;
          end else begin
            state_d = LOW_WAIT;
          end
        end
        HIGH_WAIT: begin
          if (nib_valid) begin
            push_req_s = 1'b1;
            low_d      = '0;
            timer_d    = '0;
            state_d    = LOW_WAIT;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            timeout_evt_s = 1'b1;
            low_d         = '0;
            timer_d       = '0;
            state_d       = LOW_WAIT;
          end else if (timer_q != {TW{1'b1}}) begin
            timer_d = timer_q + TW'(1);
          end else begin
            timer_d = timer_q;
          end
        end
        default: begin
          state_d = IDLE;
          low_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  assign overrun_evt_s = push_req_s && fifo_full_s && !pop_s;

  // A new error event outranks a simultaneous clear.
  always_comb begin
    if (overrun_evt_s) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (timeout_evt_s) begin
      timeout_err_d = 1'b1;
    end else if (clr_err) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      low_q         <= '0;
      timer_q       <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      low_q         <= low_d;
      timer_q       <= timer_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  rx_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req_s),
    .push_data (push_byte_s),
    .pop       (pop_s),
    .data      (out_data),
    .count     (count),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign out_valid   = !fifo_empty_s;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Directed bench for rx_byte_assembler: a byte-queue reference model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_rx_byte_assembler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] nib_data = 4'h0;
  logic       nib_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       overrun;
  logic       timeout_err;
  logic       clr_err = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  rx_byte_assembler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .nib_data(nib_data), .nib_valid(nib_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .overrun(overrun), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: running flag, pending low nibble with its age, byte queue, sticky flags.
  logic [7:0] mq[$];
  bit         m_running = 1'b0;
  bit         m_pending = 1'b0;
  logic [3:0] m_low = 4'h0;
  int         m_age = 0;
  bit         m_ovr = 1'b0;
  bit         m_tmo = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        m_running = 1'b0; m_pending = 1'b0; m_low = 4'h0; m_age = 0;
        m_ovr = 1'b0; m_tmo = 1'b0;
      end else begin
        bit pop, ovr_set, tmo_set;
        pop = (mq.size() > 0) && out_ready;
        ovr_set = 1'b0;
        tmo_set = 1'b0;
        if (pop) mq.pop_front();
        if (!enable) begin
          m_running = 1'b0;
          m_pending = 1'b0;
        end else if (!m_running) begin
          m_running = 1'b1;
        end else if (!m_pending) begin
          if (nib_valid) begin
            m_pending = 1'b1; m_low = nib_data; m_age = 0;
          end
        end else if (nib_valid) begin
          m_pending = 1'b0;
          if (mq.size() < DEPTH) mq.push_back({nib_data, m_low});
          else ovr_set = 1'b1;
        end else begin
          m_age++;
          if (m_age == TIMEOUT) begin
            m_pending = 1'b0;
            tmo_set = 1'b1;
          end
        end
        m_ovr = ovr_set ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
        m_tmo = tmo_set ? 1'b1 : (clr_err ? 1'b0 : m_tmo);
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("model_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("model_count", 32'(count), 32'(mq.size()));
      if (mq.size() > 0) check("model_out_data", 32'(out_data), 32'(mq[0]));
      check("model_overrun", 32'(overrun), 32'(m_ovr));
      check("model_timeout_err", 32'(timeout_err), 32'(m_tmo));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] v);
    nib_data = v;
    nib_valid = 1'b1;
    cyc();
    nib_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [3:0] lo, input logic [3:0] hi);
    send_nib(lo);
    send_nib(hi);
  endtask

  initial begin
    logic [7:0] exp_bytes [4];

    repeat (3) cyc();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_flags", 32'({overrun, timeout_err}), 32'd0);
    rst = 1'b1;
    cyc();

    // First byte: 0xA then 0x5
    enable = 1'b1;
    cyc();
    send_pair(4'hA, 4'h5);
    check("first_byte_data", 32'(out_data), 32'h5A);
    check("first_byte_valid", 32'(out_valid), 32'd1);
    check("first_byte_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("first_byte_drained", 32'(count), 32'd0);

    // Five pairs into a four-deep FIFO
    send_pair(4'h1, 4'h2);
    send_pair(4'h3, 4'h4);
    send_pair(4'h5, 4'h6);
    send_pair(4'h7, 4'h8);
    send_pair(4'h9, 4'hA);
    check("full_count", 32'(count), 32'd4);
    check("full_overrun", 32'(overrun), 32'd1);
    exp_bytes[0] = 8'h21; exp_bytes[1] = 8'h43; exp_bytes[2] = 8'h65; exp_bytes[3] = 8'h87;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 32'(out_data), 32'(exp_bytes[i]));
      cyc();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(count), 32'd0);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);

    // Timeout boundary: flag appears exactly TIMEOUT+1 cycles after capture
    send_nib(4'h3);
    repeat (TIMEOUT - 1) cyc();
    check("timeout_not_yet", 32'(timeout_err), 32'd0);
    cyc();
    check("timeout_set", 32'(timeout_err), 32'd1);
    send_pair(4'h1, 4'h2);
    check("after_timeout_byte", 32'(out_data), 32'h21);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Full FIFO with a pop in the same cycle as the completing nibble
    send_pair(4'h0, 4'h1);
    send_pair(4'h2, 4'h3);
    send_pair(4'h4, 4'h5);
    send_pair(4'h6, 4'h7);
    send_nib(4'hE);
    nib_data = 4'hF;
    nib_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    nib_valid = 1'b0;
    out_ready = 1'b0;
    check("pop_push_count", 32'(count), 32'd4);
    check("pop_push_no_overrun", 32'(overrun), 32'd0);
    check("pop_push_head", 32'(out_data), 32'h32);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("clr_timeout", 32'(timeout_err), 32'd0);
    exp_bytes[0] = 8'h32; exp_bytes[1] = 8'h54; exp_bytes[2] = 8'h76; exp_bytes[3] = 8'hFE;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain2_order", 32'(out_data), 32'(exp_bytes[i]));
      cyc();
    end
    out_ready = 1'b0;

    // Disable mid-byte: partial nibble dropped silently, IDLE ignores nibbles
    send_nib(4'h9);
    enable = 1'b0;
    repeat (5) cyc();
    send_nib(4'h4);
    repeat (TIMEOUT + 3) cyc();
    check("disable_no_timeout", 32'(timeout_err), 32'd0);
    enable = 1'b1;
    send_nib(4'h6);
    send_pair(4'h7, 4'h8);
    check("reenable_byte", 32'(out_data), 32'h87);
    check("reenable_count", 32'(count), 32'd1);
    check("reenable_no_timeout", 32'(timeout_err), 32'd0);

    // Overrun set while clr_err is high: the set wins
    send_pair(4'h1, 4'h1);
    send_pair(4'h2, 4'h2);
    send_pair(4'h3, 4'h3);
    send_nib(4'h4);
    nib_data = 4'h4;
    nib_valid = 1'b1;
    clr_err = 1'b1;
    cyc();
    nib_valid = 1'b0;
    clr_err = 1'b0;
    check("set_beats_clear", 32'(overrun), 32'd1);
    check("set_beats_clear_count", 32'(count), 32'd4);

    // Mid-operation reset with two bytes buffered and a low nibble pending
    out_ready = 1'b1;
    cyc();
    cyc();
    out_ready = 1'b0;
    check("pre_reset_count", 32'(count), 32'd2);
    send_nib(4'hB);
    rst = 1'b0;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_count", 32'(count), 32'd0);
    check("async_reset_flags", 32'({overrun, timeout_err}), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    send_pair(4'hC, 4'hD);
    check("post_reset_byte", 32'(out_data), 32'hDC);
    check("post_reset_count", 32'(count), 32'd1);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_byte_assembler.md
# rx_byte_assembler

Controller stage placed directly after the 4-bit serial receiver. It takes the receiver's nibble outputs and one-cycle `done` pulses, and pairs consecutive nibbles into bytes, low nibble first. It guards the gap between the two nibbles with a timeout watchdog. Completed bytes are buffered in a small FIFO that a downstream consumer drains over a valid/ready handshake.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 15: max cycles allowed in HIGH_WAIT before the partial byte is abandoned; ≥1.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `enable` in 1: assembler runs while 1.
- `nib_data` in 4: nibble from receiver `data`.
- `nib_valid` in 1: receiver `done` pulse; `nib_data` is valid in that cycle.
- `out_data` out 8: FIFO head byte, `{high_nibble, low_nibble}`.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts head.
- `count` out `$clog2(DEPTH)+1`: FIFO occupancy.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `timeout_err` out 1: sticky; a partial byte was abandoned.
- `clr_err` in 1: clears both sticky flags.

## Operation
- Reset (async, `rst`=0): state IDLE, FIFO empty, `count`=0, `out_valid`=0, `out_data`=0, `overrun`=0, `timeout_err`=0, low-nibble holding register=0, timer=0.
- FSM states:
  - IDLE → LOW_WAIT when `enable`=1.
  - LOW_WAIT: on `nib_valid`, capture `nib_data` into the low register, clear the timer, go to HIGH_WAIT.
  - HIGH_WAIT:
    - On `nib_valid`, push `{nib_data, low}` into the FIFO and go to LOW_WAIT.
    - Otherwise increment the timer. When timer == `TIMEOUT-1` with no nibble, set `timeout_err`, discard the low nibble, and go to LOW_WAIT.
  - Any state with `enable`=0: go to IDLE next cycle; a partial low nibble is discarded silently (no error). FIFO contents and flags are retained, and popping still works.
- `nib_valid` in IDLE is ignored.
- FIFO:
  - Pop when `out_valid && out_ready`.
  - Push when the second nibble arrives.
  - Full with no pop in the same cycle: the byte is dropped and `overrun` is set; FSM still returns to LOW_WAIT.
  - Full with a pop in the same cycle: the push is accepted and `count` is unchanged.
  - Empty: pop is impossible because `out_valid`=0.
  - Read/write pointers are `$clog2(DEPTH)` bits and wrap naturally.
- `clr_err` and a new error event in the same cycle: the set wins.
- Timer width: `$clog2(TIMEOUT+1)`; it saturates and never wraps.

## Timing
- Byte latency: a second-nibble `nib_valid` in cycle N gives `out_valid`=1 and `out_data` updated in cycle N+1 (from empty).
- `out_data` shows the FIFO head combinationally from registered storage. It holds stable while `out_valid && !out_ready`.
- `count` and `out_valid` update in the cycle after push/pop.
- Timeout: the low nibble is captured in cycle N. With no further nibble, `timeout_err`=1 in cycle N+`TIMEOUT`+1 and the state is LOW_WAIT.
- Error flags assert the cycle after the causing event; `clr_err` takes effect the next cycle.
- Back-to-back `nib_valid` in consecutive cycles is accepted (the receiver cannot produce it, but it is legal).
- Mid-operation reset clears everything immediately; no partial byte survives.

## Structure
- Shared package `rx_pkg`:
  - state enum `asm_state_t` {IDLE, LOW_WAIT, HIGH_WAIT}
  - `NIB_W`=4, `BYTE_W`=8
- Sub-module `rx_byte_fifo`:
  - parameterised by `DEPTH`
  - ports: push, push_data, pop, data, count, full, empty
- The FSM, timer and error flags stay in the top module.

## Test plan
- Reset then `enable`=1; nibbles 0xA then 0x5 → `out_data`=0x5A, `out_valid`=1 one cycle after the second pulse, `count`=1.
- Hold `out_ready`=0 and send 5 byte pairs with `DEPTH`=4 → `count`=4, fifth byte dropped, `overrun`=1. Then drain with `out_ready`=1 → bytes come out in order, `count`→0.
- Send a single nibble 0x3, then idle 16 cycles (`TIMEOUT`=15) → `timeout_err`=1. Next pair 0x1,0x2 → `out_data`=0x21 (0x3 discarded).
- FIFO full; assert `out_ready` in the same cycle as the second nibble → push accepted, `count` stays 4, `overrun` stays 0.
- Drop `enable` after one nibble, re-enable, send 0x7,0x8 → `out_data`=0x87, `timeout_err`=0. `clr_err` pulse clears a previously set `overrun`.
- Assert `rst`=0 with 2 bytes buffered in HIGH_WAIT → `out_valid`=0, `count`=0, flags 0 immediately.
